// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared fetch-stage constants (PC targets, IM window, exception codes)
package fetch_stage_pkg;

    localparam logic [31:0] PC_RESET   = 32'h0000_3000;
    localparam logic [31:0] PC_HANDLER = 32'h0000_4180;
    localparam logic [31:0] IM_LO      = 32'h0000_3000;
    localparam logic [31:0] IM_HI      = 32'h0000_6FFC;
    localparam logic [4:0]  EXC_NONE   = 5'd0;
    localparam logic [4:0]  EXC_AdEL   = 5'd4;

    // Instruction fetch address error: misaligned or outside the instruction memory window.
    function automatic logic fetch_addr_error(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);
    endfunction

endpackage

// File: rtl/F_PC.sv
// rtl/F_PC.sv - program counter register; Req redirect wins over stall
module F_PC
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        Req,
    input  logic [31:0] npc,
    output logic [31:0] pc
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= PC_RESET;
        end else if (Req) begin
            pc <= PC_HANDLER;
        end else if (!stall) begin
            pc <= npc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, AdEL detection and the F/D pipeline register
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        Req,
    input  logic [31:0] npc,
    input  logic        Delaycheck,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] i_inst_addr,
    output logic [31:0] F_pc,
    output logic [31:0] D_pc,
    output logic [31:0] D_instr,
    output logic [4:0]  D_excode,
    output logic        D_bd
);

    logic        f_adel;
    logic [31:0] f_instr;
    logic [4:0]  f_excode;

    F_PC u_f_pc (
        .clk   (clk),
        .reset (reset),
        .stall (stall),
        .Req   (Req),
        .npc   (npc),
        .pc    (F_pc)
    );

    assign i_inst_addr = F_pc;

    // A faulting fetch travels on as a nop carrying AdEL; the PC keeps following npc
    // until CP0 raises Req from a later stage.
    assign f_adel   = fetch_addr_error(F_pc);
    assign f_instr  = f_adel ? 32'h0 : i_inst_rdata;
    assign f_excode = f_adel ? EXC_AdEL : EXC_NONE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            D_pc     <= PC_RESET;
            D_instr  <= 32'h0;
            D_excode <= EXC_NONE;
            D_bd     <= 1'b0;
        end else if (Req) begin
            D_pc     <= PC_HANDLER;
            D_instr  <= 32'h0;
            D_excode <= EXC_NONE;
            D_bd     <= 1'b0;
        end else if (!stall) begin
            D_pc     <= F_pc;
            D_instr  <= f_instr;
            D_excode <= f_excode;
            D_bd     <= Delaycheck;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        Req;
    logic [31:0] npc;
    logic        Delaycheck;
    logic [31:0] i_inst_rdata;
    logic [31:0] i_inst_addr;
    logic [31:0] F_pc;
    logic [31:0] D_pc;
    logic [31:0] D_instr;
    logic [4:0]  D_excode;
    logic        D_bd;

    int total;
    int bad;

    fetch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .Req          (Req),
        .npc          (npc),
        .Delaycheck   (Delaycheck),
        .i_inst_rdata (i_inst_rdata),
        .i_inst_addr  (i_inst_addr),
        .F_pc         (F_pc),
        .D_pc         (D_pc),
        .D_instr      (D_instr),
        .D_excode     (D_excode),
        .D_bd         (D_bd)
    );

    // Instruction memory: word at address A reads as C0DE_<A[15:0]>.
    assign i_inst_rdata = {16'hC0DE, i_inst_addr[15:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; sample on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        stall = 1'b0;
        Req   = 1'b0;
        npc   = 32'h0;
        Delaycheck = 1'b0;

        // Reset asserted mid-cycle, together with Req and stall which it must override.
        #3;
        reset = 1'b1;
        Req   = 1'b1;
        stall = 1'b1;
        npc   = 32'h0000_5000;
        #1;
        chk("rst_async_fpc",    F_pc,             32'h0000_3000);
        chk("rst_async_dpc",    D_pc,             32'h0000_3000);
        chk("rst_async_dinstr", D_instr,          32'h0);
        chk("rst_async_exc",    {27'd0, D_excode}, 32'h0);
        chk("rst_async_bd",     {31'd0, D_bd},     32'h0);
        @(negedge clk);
        chk("rst_hold_fpc",     F_pc,             32'h0000_3000);
        chk("rst_iaddr",        i_inst_addr,      32'h0000_3000);

        reset = 1'b0;
        Req   = 1'b0;
        stall = 1'b0;
        npc   = 32'h0000_3004;
        tick();
        chk("seq1_fpc",    F_pc,    32'h0000_3004);
        chk("seq1_dpc",    D_pc,    32'h0000_3000);
        chk("seq1_dinstr", D_instr, 32'hC0DE_3000);
        npc = 32'h0000_3008;
        tick();
        chk("seq2_fpc",    F_pc,    32'h0000_3008);
        chk("seq2_dpc",    D_pc,    32'h0000_3004);
        chk("seq2_dinstr", D_instr, 32'hC0DE_3004);

        // Stall for three cycles at F_pc = 0x3010.
        npc = 32'h0000_3010;
        tick();
        chk("pre_stall_fpc", F_pc, 32'h0000_3010);
        stall = 1'b1;
        npc   = 32'h0000_3014;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_fpc",    F_pc,    32'h0000_3010);
            chk("stall_dpc",    D_pc,    32'h0000_3008);
            chk("stall_dinstr", D_instr, 32'hC0DE_3008);
        end
        stall = 1'b0;
        tick();
        chk("unstall_fpc",    F_pc,    32'h0000_3014);
        chk("unstall_dpc",    D_pc,    32'h0000_3010);
        chk("unstall_dinstr", D_instr, 32'hC0DE_3010);

        // Delay slot at 0x3020.
        npc = 32'h0000_3020;
        tick();
        chk("ds_pre_fpc", F_pc, 32'h0000_3020);
        Delaycheck = 1'b1;
        npc = 32'h0000_3024;
        tick();
        chk("ds_dpc", D_pc,            32'h0000_3020);
        chk("ds_bd",  {31'd0, D_bd},   32'h1);
        // Stalled with Delaycheck held: D_bd must stay put.
        stall = 1'b1;
        tick();
        chk("ds_stall_bd",  {31'd0, D_bd}, 32'h1);
        chk("ds_stall_dpc", D_pc,          32'h0000_3020);
        stall = 1'b0;
        Delaycheck = 1'b0;
        npc = 32'h0000_3028;
        tick();
        chk("ds_next_dpc", D_pc,          32'h0000_3024);
        chk("ds_next_bd",  {31'd0, D_bd}, 32'h0);

        // Misaligned fetch; PC keeps following npc.
        npc = 32'h0000_3002;
        tick();
        chk("al_fpc", F_pc, 32'h0000_3002);
        npc = 32'h0000_3008;
        tick();
        chk("al_exc",    {27'd0, D_excode}, 32'd4);
        chk("al_dinstr", D_instr,           32'h0);
        chk("al_dpc",    D_pc,              32'h0000_3002);
        chk("al_fpc2",   F_pc,              32'h0000_3008);

        // Above the window.
        npc = 32'h0000_7000;
        tick();
        chk("hi_pre_exc", {27'd0, D_excode}, 32'd0);
        npc = 32'h0000_6FFC;
        tick();
        chk("hi_exc",    {27'd0, D_excode}, 32'd4);
        chk("hi_dinstr", D_instr,           32'h0);
        chk("hi_dpc",    D_pc,              32'h0000_7000);

        // Last legal word, then just below the window.
        npc = 32'h0000_2FFC;
        tick();
        chk("edge_hi_exc",    {27'd0, D_excode}, 32'd0);
        chk("edge_hi_dinstr", D_instr,           32'hC0DE_6FFC);
        chk("edge_hi_dpc",    D_pc,              32'h0000_6FFC);
        npc = 32'h0000_3000;
        tick();
        chk("lo_exc",    {27'd0, D_excode}, 32'd4);
        chk("lo_dinstr", D_instr,           32'h0);
        chk("lo_dpc",    D_pc,              32'h0000_2FFC);
        npc = 32'h0000_3004;
        tick();
        chk("edge_lo_exc", {27'd0, D_excode}, 32'd0);
        chk("edge_lo_dpc", D_pc,              32'h0000_3000);

        // Req together with stall: redirect wins, F/D flushed, bd cleared.
        Req = 1'b1;
        stall = 1'b1;
        Delaycheck = 1'b1;
        npc = 32'h0000_5555;
        tick();
        chk("req_fpc",    F_pc,              32'h0000_4180);
        chk("req_dinstr", D_instr,           32'h0);
        chk("req_dpc",    D_pc,              32'h0000_4180);
        chk("req_bd",     {31'd0, D_bd},     32'h0);
        chk("req_exc",    {27'd0, D_excode}, 32'd0);
        Req = 1'b0;
        stall = 1'b0;
        Delaycheck = 1'b0;
        npc = 32'h0000_4184;
        tick();
        chk("handler_fpc",    F_pc,    32'h0000_4184);
        chk("handler_dpc",    D_pc,    32'h0000_4180);
        chk("handler_dinstr", D_instr, 32'hC0DE_4180);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 stall  in  1  hazard-unit stall; holds the PC and F/D registers.
REQ-004 Req  in  1  exception/interrupt request from CP0; flushes and redirects.
REQ-005 npc  in  32  next PC from the D-stage next-PC logic; includes the 0x4180 and EPC targets.
REQ-006 Delaycheck  in  1  D-stage instruction is a branch or jump, so the current F instruction is a delay slot.
REQ-007 i_inst_rdata  in  32  instruction word returned by the instruction memory for i_inst_addr.
REQ-008 i_inst_addr  out  32  instruction memory address; equals F_pc.
REQ-009 F_pc  out  32  current fetch PC; consumed by the next-PC logic.
REQ-010 D_pc  out  32  PC of the instruction held in the D stage.
REQ-011 D_instr  out  32  instruction held in the D stage.
REQ-012 D_excode  out  5  exception code carried into D; 0 = none.
REQ-013 D_bd  out  1  branch-delay flag of the D instruction, for CP0 Cause.BD.

Function
REQ-014 PC register: Req=1 -> PC <= 32'h0000_4180; else stall=1 -> hold; else PC <= npc.
REQ-015 Req SHALL take priority over stall in both the PC register and the F/D register.
REQ-016 Fetch error (AdEL) SHALL be detected when F_pc[1:0] != 0 or F_pc < 32'h0000_3000 or F_pc > 32'h0000_6FFC.
REQ-017 F-side excode = 5'd4 on fetch error, else 5'd0; the F-side instruction is forced to 32'h0 on fetch error.
REQ-018 F-side bd = Delaycheck, sampled in the same cycle as the F instruction.
REQ-019 F/D register: Req=1 -> D_instr <= 0, D_pc <= 32'h0000_4180, D_excode <= 0, D_bd <= 0.
REQ-020 F/D register: else stall=1 -> all D_* outputs hold.
REQ-021 F/D register: else D_* <= F-side pc, instr, excode, bd.
REQ-022 Latency: an instruction fetched at F_pc in cycle N appears on D_* in cycle N+1 when not stalled or flushed.
REQ-023 Under a continuous stall, D_bd SHALL stay constant, because Delaycheck is driven from held D state.
REQ-024 A fetch error SHALL NOT stop PC update; the PC keeps following npc until Req arrives from the later stages.
REQ-025 i_inst_addr SHALL be driven combinationally from the PC register, with no extra cycle.

Reset
REQ-026 Reset values: PC = 32'h0000_3000; D_pc = 32'h0000_3000; D_instr = 0; D_excode = 0; D_bd = 0.
REQ-027 Reset SHALL act immediately on assertion, independent of clk, and override Req and stall.
REQ-028 First fetch after reset deassertion SHALL be from 32'h0000_3000.

Structure
REQ-029 The shared macro header SHALL hold the constants PC_RESET (0x3000), PC_HANDLER (0x4180), IM_LO (0x3000), IM_HI (0x6FFC), EXC_NONE (0) and EXC_AdEL (4).
REQ-030 One sub-module, F_PC, SHALL hold the PC register with its stall and Req priority.
REQ-031 The F/D pipeline register, AdEL check and forcing logic SHALL sit in fetch_stage.

Verification
REQ-032 Reset test: assert reset mid-cycle, then release, with npc=F_pc+4 -> F_pc sequence 0x3000, 0x3004, 0x3008; D_pc lags by one cycle.
REQ-033 Stall test: stall=1 for 3 cycles at F_pc=0x3010 -> F_pc, D_pc and D_instr constant; on release F_pc=npc next edge.
REQ-034 Alignment error: npc=0x3002 -> next cycle D_excode=4, D_instr=0, D_pc=0x3002.
REQ-035 Range error: npc=0x7000 -> next cycle D_excode=4, D_instr=0, D_pc=0x7000.
REQ-036 Req with stall: Req=1 and stall=1 together -> next edge F_pc=0x4180, D_instr=0, D_pc=0x4180, D_bd=0.
REQ-037 Delay slot: Delaycheck=1 while fetching 0x3020 -> next cycle D_pc=0x3020 and D_bd=1; following instruction D_bd=0.
